// File: rtl/ysyx_24090018_wbu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24090018_wbu_pkg
// Shared definitions for the writeback/commit stage and its register file:
//   - wbu_state_e : commit FSM state encoding
//   - RESET_PC_DEF: default PC after reset
//   - REG_IDX_W / NUM_REGS : register index width and register count
//   - REG_ZERO / REG_A0    : hardwired-zero register and a0 (halt code source)
//   - ZERO_WORD            : all-zero 32-bit word
// ---------------------------------------------------------------------------
package ysyx_24090018_wbu_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_COMMIT = 2'd1,
      S_NOTIFY = 2'd2,
      S_HALT   = 2'd3
   } wbu_state_e;

   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 32;

   localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_IDX_W-1:0] REG_A0   = 5'd10;

endpackage

// File: rtl/ysyx_24090018_regfile.sv
// ---------------------------------------------------------------------------
// ysyx_24090018_regfile
// 32 x DATA_WIDTH architectural register file.
//   clk, rst            : clock, synchronous active-high clear of all entries
//   wen_i/waddr_i/wdata_i : single synchronous write port (x0 writes dropped)
//   raddr1_i/rdata1_o   : combinational read port 1 (no write bypass)
//   raddr2_i/rdata2_o   : combinational read port 2 (no write bypass)
//   a0_o                : current value of x10, used as the ebreak halt code
// ---------------------------------------------------------------------------
module ysyx_24090018_regfile
   import ysyx_24090018_wbu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wen_i,
   input  logic [REG_IDX_W-1:0]  waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [REG_IDX_W-1:0]  raddr1_i,
   input  logic [REG_IDX_W-1:0]  raddr2_i,
   output logic [DATA_WIDTH-1:0] rdata1_o,
   output logic [DATA_WIDTH-1:0] rdata2_o,
   output logic [DATA_WIDTH-1:0] a0_o
);

   localparam logic [DATA_WIDTH-1:0] W_ZERO = DATA_WIDTH'(ZERO_WORD);

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

   // Reset wins over a same-cycle write, so a commit interrupted by rst is lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= W_ZERO;
         end
      end else if (wen_i && (waddr_i != REG_ZERO)) begin
         r_regs[waddr_i] <= wdata_i;
      end
   end

   // Reads see the stored value only; a write becomes visible the cycle after.
   assign rdata1_o = (raddr1_i == REG_ZERO) ? W_ZERO : r_regs[raddr1_i];
   assign rdata2_o = (raddr2_i == REG_ZERO) ? W_ZERO : r_regs[raddr2_i];
   assign a0_o     = r_regs[REG_A0];

endmodule

// File: rtl/ysyx_24090018_wbu.sv
// ---------------------------------------------------------------------------
// ysyx_24090018_wbu
// Writeback/commit stage of the multi-cycle core. Accepts one execute result
// per handshake, commits it into the register file and PC, then offers the
// new PC to fetch. An ebreak commit freezes the stage until reset.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid_i / in_ready_o  : execute -> WBU handshake (ready only in IDLE)
//   inst_addr_i, rd_i, rf_wen_i, rf_wdata_i, jump_en_i, jump_addr_i, ebreak_i
//                            : commit payload, latched at the handshake
//   raddr1_i/raddr2_i, rdata1_o/rdata2_o : decode register read ports
//   out_valid_o / out_ready_i: WBU -> fetch new-PC handshake
//   pc_o                     : architectural PC
//   halt_o, halt_code_o      : sticky ebreak flag and a0 captured at ebreak
//   retired_o                : retired-instruction counter
// ---------------------------------------------------------------------------
module ysyx_24090018_wbu
   import ysyx_24090018_wbu_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEF),
   parameter int                    CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] inst_addr_i,
   input  logic [REG_IDX_W-1:0]  rd_i,
   input  logic                  rf_wen_i,
   input  logic [DATA_WIDTH-1:0] rf_wdata_i,
   input  logic                  jump_en_i,
   input  logic [DATA_WIDTH-1:0] jump_addr_i,
   input  logic                  ebreak_i,
   input  logic [REG_IDX_W-1:0]  raddr1_i,
   input  logic [REG_IDX_W-1:0]  raddr2_i,
   output logic [DATA_WIDTH-1:0] rdata1_o,
   output logic [DATA_WIDTH-1:0] rdata2_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic                  halt_o,
   output logic [DATA_WIDTH-1:0] halt_code_o,
   output logic [CNT_WIDTH-1:0]  retired_o
);

   // Jump targets are forced to even addresses (jalr semantics); sequential
   // flow advances by 4 and wraps modulo 2^DATA_WIDTH.
   function automatic logic [DATA_WIDTH-1:0] f_next_pc(
      input logic                  jump_en,
      input logic [DATA_WIDTH-1:0] jump_addr,
      input logic [DATA_WIDTH-1:0] inst_addr
   );
      if (jump_en) begin
         f_next_pc = jump_addr & ~DATA_WIDTH'(1);
      end else begin
         f_next_pc = inst_addr + DATA_WIDTH'(4);
      end
   endfunction

   wbu_state_e            r_state;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_pc;
   logic                  r_halt;
   logic [DATA_WIDTH-1:0] r_halt_code;
   logic [CNT_WIDTH-1:0]  r_retired;

   // Latched commit payload (data only, no reset needed).
   logic [DATA_WIDTH-1:0] r_inst_addr;
   logic [REG_IDX_W-1:0]  r_rd;
   logic                  r_rf_wen;
   logic [DATA_WIDTH-1:0] r_rf_wdata;
   logic                  r_jump_en;
   logic [DATA_WIDTH-1:0] r_jump_addr;
   logic                  r_ebreak;

   logic                  w_fire_in;
   logic                  w_rf_wen;
   logic [DATA_WIDTH-1:0] w_next_pc;
   logic [DATA_WIDTH-1:0] w_a0;

   assign w_fire_in = in_valid_i && r_in_ready;
   assign w_rf_wen  = (r_state == S_COMMIT) && r_rf_wen;
   assign w_next_pc = f_next_pc(r_jump_en, r_jump_addr, r_inst_addr);

   always_ff @(posedge clk) begin
      if (w_fire_in) begin
         r_inst_addr <= inst_addr_i;
         r_rd        <= rd_i;
         r_rf_wen    <= rf_wen_i;
         r_rf_wdata  <= rf_wdata_i;
         r_jump_en   <= jump_en_i;
         r_jump_addr <= jump_addr_i;
         r_ebreak    <= ebreak_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_pc        <= RESET_PC;
         r_halt      <= 1'b0;
         r_halt_code <= '0;
         r_retired   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_fire_in) begin
                  r_state    <= S_COMMIT;
                  r_in_ready <= 1'b0;
               end
            end
            S_COMMIT: begin
               r_pc      <= w_next_pc;
               r_retired <= r_retired + CNT_WIDTH'(1);
               if (r_ebreak) begin
                  // a0 is sampled before this cycle's write lands.
                  r_state     <= S_HALT;
                  r_halt      <= 1'b1;
                  r_halt_code <= w_a0;
               end else begin
                  r_state     <= S_NOTIFY;
                  r_out_valid <= 1'b1;
               end
            end
            S_NOTIFY: begin
               if (out_ready_i) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   ysyx_24090018_regfile #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .wen_i    (w_rf_wen),
      .waddr_i  (r_rd),
      .wdata_i  (r_rf_wdata),
      .raddr1_i (raddr1_i),
      .raddr2_i (raddr2_i),
      .rdata1_o (rdata1_o),
      .rdata2_o (rdata2_o),
      .a0_o     (w_a0)
   );

   assign in_ready_o  = r_in_ready;
   assign out_valid_o = r_out_valid;
   assign pc_o        = r_pc;
   assign halt_o      = r_halt;
   assign halt_code_o = r_halt_code;
   assign retired_o   = r_retired;

endmodule

// File: tb/tb_ysyx_24090018_wbu.sv
module tb_ysyx_24090018_wbu;

   logic        clk;
   logic        rst;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] inst_addr_i;
   logic [4:0]  rd_i;
   logic        rf_wen_i;
   logic [31:0] rf_wdata_i;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        ebreak_i;
   logic [4:0]  raddr1_i;
   logic [4:0]  raddr2_i;
   logic [31:0] rdata1_o;
   logic [31:0] rdata2_o;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] pc_o;
   logic        halt_o;
   logic [31:0] halt_code_o;
   logic [31:0] retired_o;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ret;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   ysyx_24090018_wbu dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .inst_addr_i (inst_addr_i),
      .rd_i        (rd_i),
      .rf_wen_i    (rf_wen_i),
      .rf_wdata_i  (rf_wdata_i),
      .jump_en_i   (jump_en_i),
      .jump_addr_i (jump_addr_i),
      .ebreak_i    (ebreak_i),
      .raddr1_i    (raddr1_i),
      .raddr2_i    (raddr2_i),
      .rdata1_o    (rdata1_o),
      .rdata2_o    (rdata2_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .pc_o        (pc_o),
      .halt_o      (halt_o),
      .halt_code_o (halt_code_o),
      .retired_o   (retired_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every cycle the DUT offers a new PC, it must match
   // the head expectation; the entry retires on the fetch handshake.
   always @(negedge clk) begin
      if (out_valid_o === 1'b1) begin
         if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_out_valid actual pc_o=%h expected no notify", pc_o);
         end else begin
            check("notify_pc", pc_o, q[0].pc);
            check("notify_retired", retired_o, q[0].ret);
            if (out_ready_i) void'(q.pop_front());
         end
      end
   end

   task automatic wait_idle();
      int k = 0;
      while (in_ready_o !== 1'b1 && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      if (in_ready_o !== 1'b1) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_idle_timeout actual in_ready_o=%b expected 1", in_ready_o);
      end
   endtask

   // Presents one result; returns at #1 after the handshake edge (DUT in COMMIT).
   // Payload is then scrambled to show later changes have no effect.
   task automatic issue(input logic [31:0] addr, input logic [4:0] rd, input logic wen,
                        input logic [31:0] wd, input logic jen, input logic [31:0] ja,
                        input logic eb, input logic push, input logic [31:0] epc,
                        input logic [31:0] eret);
      exp_t e;
      wait_idle();
      if (push) begin
         e.pc  = epc;
         e.ret = eret;
         q.push_back(e);
      end
      in_valid_i  = 1'b1;
      inst_addr_i = addr;
      rd_i        = rd;
      rf_wen_i    = wen;
      rf_wdata_i  = wd;
      jump_en_i   = jen;
      jump_addr_i = ja;
      ebreak_i    = eb;
      @(posedge clk); #1;
      in_valid_i  = 1'b0;
      inst_addr_i = 32'h1234_5678;
      rd_i        = 5'd7;
      rf_wen_i    = 1'b1;
      rf_wdata_i  = 32'hBAD0_BAD0;
      jump_en_i   = 1'b1;
      jump_addr_i = 32'h0000_0000;
      ebreak_i    = 1'b1;
   endtask

   initial begin
      rst         = 1'b1;
      in_valid_i  = 1'b0;
      inst_addr_i = '0;
      rd_i        = '0;
      rf_wen_i    = 1'b0;
      rf_wdata_i  = '0;
      jump_en_i   = 1'b0;
      jump_addr_i = '0;
      ebreak_i    = 1'b0;
      raddr1_i    = 5'd5;
      raddr2_i    = 5'd0;
      out_ready_i = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_pc", pc_o, 32'h8000_0000);
      check("reset_in_ready", {31'd0, in_ready_o}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("reset_retired", retired_o, 32'd0);
      check("reset_x5", rdata1_o, 32'd0);
      check("reset_halt", {31'd0, halt_o}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // addi x5 = 7 with fetch back-pressure
      out_ready_i = 1'b0;
      issue(32'h8000_0000, 5'd5, 1'b1, 32'h0000_0007, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0004, 32'd1);
      @(negedge clk);
      check("commit_no_bypass_x5", rdata1_o, 32'd0);
      check("commit_in_ready", {31'd0, in_ready_o}, 32'd0);
      check("commit_out_valid", {31'd0, out_valid_o}, 32'd0);
      @(posedge clk); #1;
      repeat (3) @(negedge clk);
      check("hold_out_valid", {31'd0, out_valid_o}, 32'd1);
      check("addi_x5", rdata1_o, 32'd7);
      @(posedge clk); #1;
      out_ready_i = 1'b1;

      // jalr with odd target
      issue(32'h8000_0010, 5'd1, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_0101, 1'b0, 1'b1, 32'h8000_0100, 32'd2);
      wait_idle();
      raddr2_i = 5'd1;
      #1;
      check("jalr_x1", rdata2_o, 32'h8000_0014);

      // write to x0 discarded
      issue(32'h8000_0100, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0104, 32'd3);
      wait_idle();
      raddr1_i = 5'd0;
      #1;
      check("x0_reads_zero", rdata1_o, 32'd0);

      // PC wrap, wen=0 must not write
      issue(32'hFFFF_FFFC, 5'd2, 1'b0, 32'h1111_1111, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0000, 32'd4);
      wait_idle();
      raddr1_i = 5'd2;
      #1;
      check("no_wen_x2", rdata1_o, 32'd0);

      // reset during COMMIT drops the pending write
      issue(32'h0000_0000, 5'd3, 1'b1, 32'h0000_0005, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      raddr1_i = 5'd3;
      raddr2_i = 5'd5;
      @(negedge clk);
      check("rstc_pc", pc_o, 32'h8000_0000);
      check("rstc_in_ready", {31'd0, in_ready_o}, 32'd1);
      check("rstc_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("rstc_retired", retired_o, 32'd0);
      check("rstc_x3", rdata1_o, 32'd0);
      check("rstc_x5_cleared", rdata2_o, 32'd0);
      repeat (3) @(posedge clk);
      #1;

      // preload a0 = 42, then ebreak writing a0 = 99
      issue(32'h8000_0000, 5'd10, 1'b1, 32'd42, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0004, 32'd1);
      wait_idle();
      issue(32'h8000_0004, 5'd10, 1'b1, 32'd99, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      raddr1_i = 5'd10;
      @(negedge clk);
      check("halt_flag", {31'd0, halt_o}, 32'd1);
      check("halt_code_old_a0", halt_code_o, 32'd42);
      check("ebreak_x10", rdata1_o, 32'd99);
      check("halt_in_ready", {31'd0, in_ready_o}, 32'd0);
      check("halt_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("halt_pc", pc_o, 32'h8000_0008);
      check("halt_retired", retired_o, 32'd2);

      // further input ignored while halted
      @(posedge clk); #1;
      in_valid_i  = 1'b1;
      inst_addr_i = 32'h8000_0040;
      rd_i        = 5'd10;
      rf_wen_i    = 1'b1;
      rf_wdata_i  = 32'd7;
      jump_en_i   = 1'b1;
      jump_addr_i = 32'h8000_0200;
      ebreak_i    = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("halted_pc", pc_o, 32'h8000_0008);
      check("halted_retired", retired_o, 32'd2);
      check("halted_x10", rdata1_o, 32'd99);
      check("halted_in_ready", {31'd0, in_ready_o}, 32'd0);
      check("halted_flag", {31'd0, halt_o}, 32'd1);
      check("halted_code", halt_code_o, 32'd42);
      in_valid_i = 1'b0;

      check("queue_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
